// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - system-clock-domain JTAG TAP controller with IDCODE/BYPASS data registers
//
// Purpose:
//   Samples an already-synchronized TCK, detects its edges in the clk domain and
//   runs the 16-state TAP FSM on TCK rising edges. Holds the instruction register
//   and the IDCODE and BYPASS data registers. TDO and the update pulses are
//   produced on TCK falling edges.
//
// Ports:
//   clk        in   system clock, rising edge
//   n_rst      in   asynchronous active-low reset
//   tck_sync   in   synchronized TCK (synchronizer resets low)
//   tms_sync   in   synchronized TMS
//   tdi_sync   in   synchronized TDI
//   tdo        out  registered serial data out
//   tdo_en     out  high while a shift state drives tdo
//   tap_state  out  current TAP state encoding
//   ir_value   out  active instruction
//   update_dr  out  1-clk pulse on TCK fall in Update-DR
//   update_ir  out  1-clk pulse on TCK fall in Update-IR

module jtag_tap_fsm #(
  parameter int                     IR_WIDTH   = 4,
  parameter logic [IR_WIDTH-1:0]    IDCODE_OP  = IR_WIDTH'(1),
  parameter logic [31:0]            IDCODE_VAL = 32'h1000_0001
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                tck_sync,
  input  logic                tms_sync,
  input  logic                tdi_sync,
  output logic                tdo,
  output logic                tdo_en,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_value,
  output logic                update_dr,
  output logic                update_ir
);

  localparam logic [3:0] S_TLR    = 4'h0;
  localparam logic [3:0] S_RTI    = 4'h1;
  localparam logic [3:0] S_SEL_DR = 4'h2;
  localparam logic [3:0] S_CAP_DR = 4'h3;
  localparam logic [3:0] S_SH_DR  = 4'h4;
  localparam logic [3:0] S_EX1_DR = 4'h5;
  localparam logic [3:0] S_PA_DR  = 4'h6;
  localparam logic [3:0] S_EX2_DR = 4'h7;
  localparam logic [3:0] S_UPD_DR = 4'h8;
  localparam logic [3:0] S_SEL_IR = 4'h9;
  localparam logic [3:0] S_CAP_IR = 4'hA;
  localparam logic [3:0] S_SH_IR  = 4'hB;
  localparam logic [3:0] S_EX1_IR = 4'hC;
  localparam logic [3:0] S_PA_IR  = 4'hD;
  localparam logic [3:0] S_EX2_IR = 4'hE;
  localparam logic [3:0] S_UPD_IR = 4'hF;

  // Fixed IR capture pattern: LSBs 01 let a debugger verify the IR chain length.
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  logic                tck_prev_q, tck_prev_d;
  logic [3:0]          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_value_q, ir_value_d;
  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [31:0]         dr_shift_q, dr_shift_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;
  logic                update_dr_q, update_dr_d;
  logic                update_ir_q, update_ir_d;

  logic                tck_rise, tck_fall;
  logic                idcode_sel;
  logic [3:0]          state_next;

  assign tck_rise   = tck_sync & ~tck_prev_q;
  assign tck_fall   = ~tck_sync & tck_prev_q;
  assign idcode_sel = (ir_value_q == IDCODE_OP);

  always_comb begin
    state_next = S_TLR;
    unique case (state_q)
      S_TLR:                     state_next = tms_sync ? S_TLR    : S_RTI;
      S_RTI, S_UPD_DR, S_UPD_IR: state_next = tms_sync ? S_SEL_DR : S_RTI;
      S_SEL_DR:                  state_next = tms_sync ? S_SEL_IR : S_CAP_DR;
      S_SEL_IR:                  state_next = tms_sync ? S_TLR    : S_CAP_IR;
      S_CAP_DR, S_SH_DR:         state_next = tms_sync ? S_EX1_DR : S_SH_DR;
      S_EX1_DR:                  state_next = tms_sync ? S_UPD_DR : S_PA_DR;
      S_PA_DR:                   state_next = tms_sync ? S_EX2_DR : S_PA_DR;
      S_EX2_DR:                  state_next = tms_sync ? S_UPD_DR : S_SH_DR;
      S_CAP_IR, S_SH_IR:         state_next = tms_sync ? S_EX1_IR : S_SH_IR;
      S_EX1_IR:                  state_next = tms_sync ? S_UPD_IR : S_PA_IR;
      S_PA_IR:                   state_next = tms_sync ? S_EX2_IR : S_PA_IR;
      S_EX2_IR:                  state_next = tms_sync ? S_UPD_IR : S_SH_IR;
      default:                   state_next = S_TLR;
    endcase
  end

  always_comb begin
    tck_prev_d  = tck_sync;
    state_d     = state_q;
    ir_value_d  = ir_value_q;
    ir_shift_d  = ir_shift_q;
    dr_shift_d  = dr_shift_q;
    bypass_d    = bypass_q;
    tdo_d       = tdo_q;
    tdo_en_d    = tdo_en_q;
    update_dr_d = 1'b0;
    update_ir_d = 1'b0;

    if (tck_rise) begin
      // Capture/shift act on the state being left, then the FSM advances.
      state_d = state_next;
      unique case (state_q)
        S_CAP_IR: ir_shift_d = IR_CAPTURE;
        S_SH_IR:  ir_shift_d = {tdi_sync, ir_shift_q[IR_WIDTH-1:1]};
        S_CAP_DR: begin
          if (idcode_sel) dr_shift_d = IDCODE_VAL;
          else            bypass_d   = 1'b0;
        end
        S_SH_DR: begin
          if (idcode_sel) dr_shift_d = {tdi_sync, dr_shift_q[31:1]};
          else            bypass_d   = tdi_sync;
        end
        default: ;
      endcase
    end else if (tck_fall) begin
      tdo_en_d = 1'b0;
      unique case (state_q)
        S_SH_IR: begin
          tdo_d    = ir_shift_q[0];
          tdo_en_d = 1'b1;
        end
        S_SH_DR: begin
          tdo_d    = idcode_sel ? dr_shift_q[0] : bypass_q;
          tdo_en_d = 1'b1;
        end
        S_UPD_IR: begin
          ir_value_d  = ir_shift_q;
          update_ir_d = 1'b1;
        end
        S_UPD_DR: update_dr_d = 1'b1;
        S_TLR:    ir_value_d  = IDCODE_OP;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tck_prev_q  <= 1'b0;
      state_q     <= S_TLR;
      ir_value_q  <= IDCODE_OP;
      ir_shift_q  <= '0;
      dr_shift_q  <= '0;
      bypass_q    <= 1'b0;
      tdo_q       <= 1'b0;
      tdo_en_q    <= 1'b0;
      update_dr_q <= 1'b0;
      update_ir_q <= 1'b0;
    end else begin
      tck_prev_q  <= tck_prev_d;
      state_q     <= state_d;
      ir_value_q  <= ir_value_d;
      ir_shift_q  <= ir_shift_d;
      dr_shift_q  <= dr_shift_d;
      bypass_q    <= bypass_d;
      tdo_q       <= tdo_d;
      tdo_en_q    <= tdo_en_d;
      update_dr_q <= update_dr_d;
      update_ir_q <= update_ir_d;
    end
  end

  assign tdo       = tdo_q;
  assign tdo_en    = tdo_en_q;
  assign tap_state = state_q;
  assign ir_value  = ir_value_q;
  assign update_dr = update_dr_q;
  assign update_ir = update_ir_q;

endmodule

// File: tb/tb_jtag_tap_fsm.sv
// tb/tb_jtag_tap_fsm.sv - self-checking bench for jtag_tap_fsm

module tb_jtag_tap_fsm;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tck_sync = 1'b0;
  logic       tms_sync = 1'b0;
  logic       tdi_sync = 1'b0;
  logic       tdo, tdo_en, update_dr, update_ir;
  logic [3:0] tap_state;
  logic [3:0] ir_value;

  jtag_tap_fsm #(.IR_WIDTH(4), .IDCODE_OP(4'b0001), .IDCODE_VAL(32'h1000_0001)) dut (
    .clk(clk), .n_rst(n_rst), .tck_sync(tck_sync), .tms_sync(tms_sync), .tdi_sync(tdi_sync),
    .tdo(tdo), .tdo_en(tdo_en), .tap_state(tap_state), .ir_value(ir_value),
    .update_dr(update_dr), .update_ir(update_ir)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model: named-state transition table plus plain shift arithmetic.
  int         nxt[16][2];
  int         m_state;
  bit         m_tck_prev;
  bit [3:0]   m_ir, m_irs;
  bit [31:0]  m_dr;
  bit         m_byp, m_tdo, m_tdo_en, m_upd_dr, m_upd_ir;

  int         cnt_upd_dr, cnt_upd_ir;
  bit         q_tdo[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_tck_prev = 0; m_ir = 4'b0001; m_irs = 0; m_dr = 0; m_byp = 0;
    m_tdo = 0; m_tdo_en = 0; m_upd_dr = 0; m_upd_ir = 0;
  endtask

  task automatic model_edge();
    bit rise, fall;
    rise = tck_sync && !m_tck_prev;
    fall = !tck_sync && m_tck_prev;
    m_upd_dr = 0;
    m_upd_ir = 0;
    if (rise) begin
      if (m_state == 10) m_irs = 4'b0001;
      if (m_state == 11) m_irs = (m_irs >> 1) | (4'(tdi_sync) << 3);
      if (m_state == 3) begin
        if (m_ir == 4'b0001) m_dr = 32'h1000_0001; else m_byp = 0;
      end
      if (m_state == 4) begin
        if (m_ir == 4'b0001) m_dr = (m_dr >> 1) | (32'(tdi_sync) << 31); else m_byp = tdi_sync;
      end
      m_state = nxt[m_state][tms_sync];
    end else if (fall) begin
      m_tdo_en = 0;
      if (m_state == 11) begin m_tdo = m_irs[0]; m_tdo_en = 1; end
      if (m_state == 4) begin m_tdo = (m_ir == 4'b0001) ? m_dr[0] : m_byp; m_tdo_en = 1; end
      if (m_state == 15) begin m_ir = m_irs; m_upd_ir = 1; end
      if (m_state == 8) m_upd_dr = 1;
      if (m_state == 0) m_ir = 4'b0001;
    end
    m_tck_prev = tck_sync;
  endtask

  task automatic compare_all();
    check("tap_state", 32'(tap_state), 32'(m_state));
    check("ir_value",  32'(ir_value),  32'(m_ir));
    check("tdo",       32'(tdo),       32'(m_tdo));
    check("tdo_en",    32'(tdo_en),    32'(m_tdo_en));
    check("update_dr", 32'(update_dr), 32'(m_upd_dr));
    check("update_ir", 32'(update_ir), 32'(m_upd_ir));
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
    if (!n_rst) model_reset(); else model_edge();
    if (update_dr) cnt_upd_dr++;
    if (update_ir) cnt_upd_ir++;
    compare_all();
  endtask

  // One TCK period: 3 clk high, 3 clk low. Records tdo when the fall was in a shift state.
  task automatic tick(input bit tms, input bit tdi);
    @(negedge clk);
    tms_sync = tms; tdi_sync = tdi; tck_sync = 1'b1;
    repeat (3) clk_step();
    @(negedge clk);
    tck_sync = 1'b0;
    repeat (3) clk_step();
    if (m_state == 4 || m_state == 11) q_tdo.push_back(tdo);
  endtask

  logic [31:0] word;
  int          walk_exp[19] = '{1, 2, 3, 4, 5, 6, 7, 8, 2, 9, 10, 11, 12, 13, 14, 15, 2, 9, 0};
  bit          walk_tms[19] = '{0, 1, 0, 0, 1, 0, 1, 1, 1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1};

  initial begin
    nxt[0]  = '{1, 0};   nxt[1]  = '{1, 2};   nxt[2]  = '{3, 9};   nxt[3]  = '{4, 5};
    nxt[4]  = '{4, 5};   nxt[5]  = '{6, 8};   nxt[6]  = '{6, 7};   nxt[7]  = '{4, 8};
    nxt[8]  = '{1, 2};   nxt[9]  = '{10, 0};  nxt[10] = '{11, 12}; nxt[11] = '{11, 12};
    nxt[12] = '{13, 15}; nxt[13] = '{13, 14}; nxt[14] = '{11, 15}; nxt[15] = '{1, 2};
    model_reset();

    // Reset values.
    repeat (3) clk_step();
    check("rst_state", 32'(tap_state), 32'h0);
    check("rst_ir", 32'(ir_value), 32'h1);
    check("rst_tdo_en", 32'(tdo_en), 32'h0);
    @(negedge clk); n_rst = 1'b1;
    repeat (2) clk_step();

    // Five TMS=1 clocks keep/return to Test-Logic-Reset.
    repeat (5) tick(1, 0);
    check("tlr_state", 32'(tap_state), 32'h0);
    check("tlr_ir", 32'(ir_value), 32'h1);
    check("tlr_tdo_en", 32'(tdo_en), 32'h0);

    // IDCODE read: TLR -> RTI -> SEL_DR -> CAP_DR -> SH_DR, 32 bits out.
    q_tdo.delete();
    tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 32; i++) tick(i == 31, 0);
    check("idcode_len", 32'(q_tdo.size()), 32'd32);
    word = '0;
    for (int i = 0; i < 32 && i < q_tdo.size(); i++) word[i] = q_tdo[i];
    check("idcode_val", word, 32'h1000_0001);
    tick(1, 0); tick(0, 0);
    check("idcode_rti", 32'(tap_state), 32'h1);

    // IR load of 4'hF.
    q_tdo.delete();
    cnt_upd_ir = 0;
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 4; i++) tick(i == 3, 1);
    tick(1, 0); tick(0, 0);
    check("ir_len", 32'(q_tdo.size()), 32'd4);
    check("ir_tdo0", 32'(q_tdo.size() > 0 ? q_tdo[0] : 1'bx), 32'h1);
    check("ir_tdo1", 32'(q_tdo.size() > 1 ? q_tdo[1] : 1'bx), 32'h0);
    check("upd_ir_count", 32'(cnt_upd_ir), 32'd1);
    check("ir_new", 32'(ir_value), 32'hF);

    // BYPASS: pattern 1,0,1,1 reappears one TCK late behind a leading 0.
    q_tdo.delete();
    cnt_upd_dr = 0;
    tick(1, 0); tick(0, 0); tick(0, 0);
    tick(0, 1); tick(0, 0); tick(0, 1); tick(1, 1);
    tick(1, 0); tick(0, 0);
    check("byp_len", 32'(q_tdo.size()), 32'd4);
    word = '0;
    for (int i = 0; i < 4 && i < q_tdo.size(); i++) word[i] = q_tdo[i];
    check("byp_bits", word, 32'b1010);
    check("upd_dr_count", 32'(cnt_upd_dr), 32'd1);

    // Five TMS=1 from RTI with IR=F: back to TLR and IDCODE.
    repeat (5) tick(1, 0);
    check("tlr2_state", 32'(tap_state), 32'h0);
    check("tlr2_ir", 32'(ir_value), 32'h1);

    // Walk all 16 states; idle clocks between ticks are checked by the model.
    for (int i = 0; i < 19; i++) begin
      tick(walk_tms[i], 0);
      check($sformatf("walk%0d", i), 32'(tap_state), 32'(walk_exp[i]));
      repeat (2) clk_step();
    end

    // Reset in the middle of SH_DR.
    tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 1); tick(0, 0);
    check("pre_rst_shdr", 32'(tap_state), 32'h4);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("arst_state", 32'(tap_state), 32'h0);
    check("arst_ir", 32'(ir_value), 32'h1);
    check("arst_tdo", 32'(tdo), 32'h0);
    check("arst_tdo_en", 32'(tdo_en), 32'h0);
    check("arst_upd", 32'({update_dr, update_ir}), 32'h0);
    model_reset();
    repeat (2) clk_step();
    @(negedge clk); n_rst = 1'b1;
    cnt_upd_dr = 0;
    repeat (5) tick(1, 0);
    check("arst_no_upd_dr", 32'(cnt_upd_dr), 32'd0);
    check("arst_final", 32'(tap_state), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
